// File: rtl/btn_event_arb_if.sv
// btn_event_arb_if: button/switch inputs and guess-event outputs of the button front end
interface btn_event_arb_if #(
   parameter int N_BTN = 5,
   parameter int GW    = $clog2(N_BTN + 1)
);
   logic [N_BTN-1:0] btn;
   logic             sw;
   logic             guess_now;
   logic [GW-1:0]    user_guess;
   logic             eval_now;
   logic             rst;
   logic [N_BTN-1:0] btn_level;
   modport master (output btn, sw, guess_now, input user_guess, eval_now, rst, btn_level);
   modport slave  (input btn, sw, guess_now, output user_guess, eval_now, rst, btn_level);
endinterface

// File: rtl/btn_event_arb.sv
// btn_event_arb: sync, tick-debounce, press-detect and lowest-index arbitration of N buttons
// into one-cycle guess events. Define BTN_EVENT_ARB_REPEAT_EN for auto-repeat while held.
module btn_event_arb #(
   parameter int N_BTN        = 5,
   parameter int DIV_W        = 17,
   parameter int STABLE       = 3,
   parameter int REPEAT_TICKS = 32,
   parameter int GW           = $clog2(N_BTN + 1)
) (
   input logic              clk,
   input logic              rst_n,
   btn_event_arb_if.slave   bus
);
   if (STABLE < 2 || STABLE > 8 || REPEAT_TICKS < 1) begin : g_bad_cfg
      $error("btn_event_arb: STABLE must be 2..8 and REPEAT_TICKS >= 1");
   end
   logic [N_BTN-1:0]             btn_s1_q, btn_s2_q, level_q, level_d, level_dly_q, press, rep_hit;
   logic                         sw_s1_q, sw_s2_q, tick_q, tick_d, eval_q, eval_d;
   logic [DIV_W-1:0]             div_q, div_d;
   logic [N_BTN-1:0][STABLE-1:0] hist_q, hist_d;
   logic [GW-1:0]                guess_q, guess_d, win;
   // divider tick and per-channel history shift / debounced level decision
   always_comb begin
      div_d  = div_q + DIV_W'(1);
      tick_d = (div_d == '0);
      hist_d  = hist_q;
      level_d = level_q;
      for (int i = 0; i < N_BTN; i++) begin
         hist_d[i]  = tick_q ? {hist_q[i][STABLE-2:0], btn_s2_q[i]} : hist_q[i];
         level_d[i] = (&hist_q[i]) ? 1'b1 : (~|hist_q[i]) ? 1'b0 : level_q[i];
      end
   end
`ifdef BTN_EVENT_ARB_REPEAT_EN
   localparam int RC_W = $clog2(REPEAT_TICKS + 1);
   logic [N_BTN-1:0][RC_W-1:0] rep_q, rep_d;
   // hold-time tick counters; a hit re-raises press and restarts the count
   always_comb begin
      rep_d   = rep_q;
      rep_hit = '0;
      for (int i = 0; i < N_BTN; i++) begin
         rep_hit[i] = level_q[i] & tick_q & (rep_q[i] == RC_W'(REPEAT_TICKS - 1));
         rep_d[i]   = (!level_q[i] || rep_hit[i]) ? '0 : tick_q ? rep_q[i] + RC_W'(1) : rep_q[i];
      end
   end
   // repeat counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else        rep_q <= rep_d;
   end
`else
   assign rep_hit = '0;
`endif
   // press detect and lowest-index arbitration; presses without guess_now are dropped
   always_comb begin
      press = (level_q & ~level_dly_q) | rep_hit;
      win   = GW'(N_BTN);
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press[i]) win = GW'(i);
      end
      eval_d  = bus.guess_now & (|press);
      guess_d = eval_d ? win : guess_q;
   end
   // all front-end state, cleared asynchronously so a mid-debounce reset leaves nothing behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         sw_s1_q     <= 1'b0;
         sw_s2_q     <= 1'b0;
         div_q       <= '0;
         tick_q      <= 1'b0;
         hist_q      <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         eval_q      <= 1'b0;
         guess_q     <= GW'(N_BTN);
      end else begin
         btn_s1_q    <= bus.btn;
         btn_s2_q    <= btn_s1_q;
         sw_s1_q     <= bus.sw;
         sw_s2_q     <= sw_s1_q;
         div_q       <= div_d;
         tick_q      <= tick_d;
         hist_q      <= hist_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         eval_q      <= eval_d;
         guess_q     <= guess_d;
      end
   end
   assign bus.user_guess = guess_q;
   assign bus.eval_now   = eval_q;
   assign bus.rst        = sw_s2_q;
   assign bus.btn_level  = level_q;
endmodule

// File: tb/tb_btn_event_arb.sv
// tb_btn_event_arb: vector table plus hand sequences; expected guess events go through a queue
module tb_btn_event_arb;
   localparam int N = 5;
   localparam int GW = 3;
   typedef struct {
      logic [N-1:0] btn;
      logic         gn;
      logic         evt;
      int           guess;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   cyc;
   int   last;
   int   exp_q[$];
   vec_t tbl[8];
   btn_event_arb_if #(.N_BTN(N)) bus ();
   btn_event_arb #(.N_BTN(N), .DIV_W(4), .STABLE(3), .REPEAT_TICKS(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // cycles since reset release, used to place stimulus relative to the sampling tick
   always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic wait_clk(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic align();
      for (int k = 0; k < 32 && cyc % 16 != 0; k++) @(negedge clk);
   endtask
   // scoreboard: every eval_now pulse must match the oldest expected guess
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.eval_now === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_eval: got user_guess=%0d expected no event", bus.user_guess);
         end else begin
            chk("eval_guess", 32'(bus.user_guess), 32'(exp_q.pop_front()));
         end
      end
   end
   initial begin
      tbl[0] = '{5'b00100, 1'b1, 1'b1, 2};
      tbl[1] = '{5'b01010, 1'b1, 1'b1, 1};
      tbl[2] = '{5'b10000, 1'b0, 1'b0, 0};
      tbl[3] = '{5'b10001, 1'b1, 1'b1, 0};
      tbl[4] = '{5'b11000, 1'b1, 1'b1, 3};
      tbl[5] = '{5'b00000, 1'b1, 1'b0, 0};
      tbl[6] = '{5'b11111, 1'b1, 1'b1, 0};
      tbl[7] = '{5'b10000, 1'b1, 1'b1, 4};
      bus.btn = '1;
      bus.sw = 1'b1;
      bus.guess_now = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      wait_clk(4);
      chk("rst_user_guess", 32'(bus.user_guess), 5);
      chk("rst_eval_now", 32'(bus.eval_now), 0);
      chk("rst_btn_level", 32'(bus.btn_level), 0);
      chk("rst_rst", 32'(bus.rst), 0);
      bus.btn = '0;
      bus.sw = 1'b0;
      rst_n = 1'b1;
      wait_clk(200);
      chk("idle_user_guess", 32'(bus.user_guess), 5);
      chk("idle_btn_level", 32'(bus.btn_level), 0);
      bus.sw = 1'b1;
      wait_clk(1);
      chk("sw_sync_1clk", 32'(bus.rst), 0);
      wait_clk(1);
      chk("sw_sync_2clk", 32'(bus.rst), 1);
      bus.sw = 1'b0;
      wait_clk(2);
      chk("sw_sync_low", 32'(bus.rst), 0);
      last = 5;
      for (int v = 0; v < 8; v++) begin
         bus.guess_now = tbl[v].gn;
         bus.btn = tbl[v].btn;
         if (tbl[v].evt) begin
            exp_q.push_back(tbl[v].guess);
            last = tbl[v].guess;
         end
         wait_clk(48);
         bus.btn = '0;
         wait_clk(8);
         chk($sformatf("vec%0d_level_high", v), 32'(bus.btn_level), 32'(tbl[v].btn));
         wait_clk(80);
         chk($sformatf("vec%0d_level_low", v), 32'(bus.btn_level), 0);
         chk($sformatf("vec%0d_guess_held", v), 32'(bus.user_guess), 32'(last));
         chk($sformatf("vec%0d_events_left", v), 32'(exp_q.size()), 0);
      end
      bus.guess_now = 1'b0;
      align();
      bus.btn = 5'b10000;
      wait_clk(52);
      chk("gate_level_up", 32'(bus.btn_level), 32'(5'b10000));
      bus.guess_now = 1'b1;
      wait_clk(4);
      bus.btn = '0;
      wait_clk(80);
      chk("gate_guess_held", 32'(bus.user_guess), 32'(last));
      chk("gate_events_left", 32'(exp_q.size()), 0);
      align();
      for (int k = 0; k < 4; k++) begin
         bus.btn = 5'b00010;
         wait_clk(8);
         bus.btn = '0;
         wait_clk(8);
      end
      chk("bounce_level_mid", 32'(bus.btn_level), 0);
      wait_clk(80);
      chk("bounce_level", 32'(bus.btn_level), 0);
      chk("bounce_guess_held", 32'(bus.user_guess), 32'(last));
      bus.btn = 5'b00100;
      exp_q.push_back(2);
      wait_clk(56);
      chk("prereset_level", 32'(bus.btn_level), 32'(5'b00100));
      chk("prereset_guess", 32'(bus.user_guess), 2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", 32'(bus.btn_level), 0);
      chk("async_rst_guess", 32'(bus.user_guess), 5);
      chk("async_rst_eval", 32'(bus.eval_now), 0);
      wait_clk(3);
      rst_n = 1'b1;
      exp_q.push_back(2);
      wait_clk(56);
      bus.btn = '0;
      wait_clk(80);
      chk("held_thru_rst_guess", 32'(bus.user_guess), 2);
      chk("held_thru_rst_events", 32'(exp_q.size()), 0);
      align();
      bus.btn = 5'b00001;
      exp_q.push_back(0);
`ifdef BTN_EVENT_ARB_REPEAT_EN
      for (int k = 0; k < 4; k++) exp_q.push_back(0);
`endif
      wait_clk(304);
      bus.btn = '0;
      wait_clk(80);
      chk("repeat_guess", 32'(bus.user_guess), 0);
      chk("repeat_events_left", 32'(exp_q.size()), 0);
      wait_clk(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
